ddr2_line_bridge: RTL and testbench



---
 rtl/ddr2_line_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_ddr2_line_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_line_bridge.sv
// ddr2_line_bridge
// Bridges 128-bit line requests from the direct-mapped L1 data cache onto a
// MIG-style DDR2 user interface. Writebacks are posted into a one-entry write
// buffer. Reads return the whole line with a single-cycle ddr2_available pulse.
// A buffered writeback is always issued to DDR2 before a later line read.
//
// Ports:
//   clk, rstn            system clock, asynchronous active-low reset
//   ddr2_enable          cache request valid (level, held until serviced)
//   ddr2_read            1 = line read, 0 = line writeback
//   ddr2_addr            request byte address (low 4 bits ignored)
//   ddr2_wdata           writeback line data
//   ddr2_available       one-cycle pulse, read line valid on ddr2_data
//   ddr2_data            last read line (held until the next read completes)
//   app_*                MIG user-interface command / write / read channels
//   bridge_error         sticky read-timeout flag
//
// Optional feature: define DDR2_TIMEOUT_EN to add a read watchdog of
// TIMEOUT_CYCLES cycles. Without it bridge_error is tied 0 and a read waits
// for the MIG indefinitely.

module ddr2_line_bridge #(
    parameter int ADDR_W         = 27,
    parameter int LINE_W         = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                ddr2_enable,
    input  logic                ddr2_read,
    input  logic [ADDR_W-1:0]   ddr2_addr,
    input  logic [LINE_W-1:0]   ddr2_wdata,
    output logic                ddr2_available,
    output logic [LINE_W-1:0]   ddr2_data,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    output logic [LINE_W-1:0]   app_wdf_data,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [LINE_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_rdy,
    input  logic [LINE_W-1:0]   app_rd_data,
    input  logic                app_rd_data_valid,
    output logic                bridge_error
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        ACK
    } stateT;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    stateT               r_state;
    stateT               w_nextState;
    logic                r_wbufValid;
    logic [ADDR_W-1:0]   r_wbufAddr;
    logic [LINE_W-1:0]   r_wbufData;
    logic                r_rdPending;
    logic [ADDR_W-1:0]   r_rdAddr;
    logic                r_cmdDone;
    logic                r_dataDone;
    logic                r_dataReg;
    logic [LINE_W-1:0]   r_ddr2Data;
    logic [ADDR_W-1:0]   w_alignedAddr;
    logic                w_wrCapture;
    logic                w_rdCapture;
    logic                w_wrDone;
    logic                w_timeout;
    logic                w_inRead;

    // Masking keeps every address bit in use while forcing line alignment.
    assign w_alignedAddr = ddr2_addr & ~ADDR_W'(15);

    // The state != ACK term stops the still-high ddr2_enable from re-capturing
    // the read that is being acknowledged this cycle.
    assign w_wrCapture = ddr2_enable && !ddr2_read && !r_wbufValid;
    assign w_rdCapture = ddr2_enable && ddr2_read && !r_rdPending && (r_state != ACK);
    assign w_inRead    = (r_state == RD_ISSUE) || (r_state == RD_WAIT);

    assign ddr2_available = (r_state == ACK);
    assign ddr2_data      = r_ddr2Data;
    assign app_wdf_end    = app_wdf_wren;
    assign app_wdf_mask   = '0;

`ifdef DDR2_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_toCnt;
    logic             r_error;

    // >= rather than == so a late command accept cannot step past the limit.
    assign w_timeout    = w_inRead && (r_toCnt >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign bridge_error = r_error;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_toCnt <= '0;
            r_error <= 1'b0;
        end else begin
            r_toCnt <= w_inRead ? r_toCnt + 1'b1 : '0;
            if (w_timeout && (w_nextState == ACK)) begin
                r_error <= 1'b1;
            end
        end
    end
`else
    assign w_timeout    = 1'b0;
    assign bridge_error = 1'b0;
`endif

    // Next-state and MIG-facing outputs. Address and data are only driven
    // while a command is in flight so the bus idles at zero.
    always_comb begin
        w_nextState  = r_state;
        app_en       = 1'b0;
        app_cmd      = CMD_WRITE;
        app_addr     = '0;
        app_wdf_wren = 1'b0;
        app_wdf_data = '0;
        w_wrDone     = 1'b0;
        r_dataReg    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_wbufValid) begin
                    w_nextState = WR_ISSUE;
                end else if (r_rdPending) begin
                    w_nextState = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                app_en       = !r_cmdDone;
                app_cmd      = CMD_WRITE;
                app_addr     = r_wbufAddr;
                app_wdf_wren = !r_dataDone;
                app_wdf_data = r_wbufData;
                if ((r_cmdDone || app_rdy) && (r_dataDone || app_wdf_rdy)) begin
                    w_wrDone    = 1'b1;
                    w_nextState = IDLE;
                end
            end
            RD_ISSUE: begin
                app_en   = 1'b1;
                app_cmd  = CMD_READ;
                app_addr = r_rdAddr;
                if (app_rdy) begin
                    w_nextState = RD_WAIT;
                end else if (w_timeout) begin
                    w_nextState = ACK;
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    r_dataReg   = 1'b1;
                    w_nextState = ACK;
                end else if (w_timeout) begin
                    w_nextState = ACK;
                end
            end
            ACK: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register plus the write buffer, pending read and handshake flags.
    // Command and write-data handshakes finish independently; each flag
    // remembers that its half was accepted until both are done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_wbufValid <= 1'b0;
            r_wbufAddr  <= '0;
            r_wbufData  <= '0;
            r_rdPending <= 1'b0;
            r_rdAddr    <= '0;
            r_cmdDone   <= 1'b0;
            r_dataDone  <= 1'b0;
            r_ddr2Data  <= '0;
        end else begin
            r_state <= w_nextState;

            if (w_wrCapture) begin
                r_wbufValid <= 1'b1;
                r_wbufAddr  <= w_alignedAddr;
                r_wbufData  <= ddr2_wdata;
            end else if (w_wrDone) begin
                r_wbufValid <= 1'b0;
            end

            if (w_rdCapture) begin
                r_rdPending <= 1'b1;
                r_rdAddr    <= w_alignedAddr;
            end else if (r_state == ACK) begin
                r_rdPending <= 1'b0;
            end

            if ((r_state == WR_ISSUE) && !w_wrDone) begin
                r_cmdDone  <= r_cmdDone || app_rdy;
                r_dataDone <= r_dataDone || app_wdf_rdy;
            end else begin
                r_cmdDone  <= 1'b0;
                r_dataDone <= 1'b0;
            end

            // A timed-out read returns an all-zero line.
            if (r_dataReg) begin
                r_ddr2Data <= app_rd_data;
            end else if (w_timeout && (w_nextState == ACK)) begin
                r_ddr2Data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_line_bridge.sv
// tb_ddr2_line_bridge
// Self-checking bench for ddr2_line_bridge. A table of line reads with an
// immediately responding MIG is replayed in a loop, followed by hand-written
// sequences for writeback ordering, handshake backpressure, dropped writes,
// the optional read watchdog and reset in the middle of a read.

module tb_ddr2_line_bridge;

    localparam int ADDR_W = 27;
    localparam int LINE_W = 128;

    logic                clk;
    logic                rstn;
    logic                ddr2_enable;
    logic                ddr2_read;
    logic [ADDR_W-1:0]   ddr2_addr;
    logic [LINE_W-1:0]   ddr2_wdata;
    logic                ddr2_available;
    logic [LINE_W-1:0]   ddr2_data;
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic                app_rdy;
    logic [LINE_W-1:0]   app_wdf_data;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic [LINE_W/8-1:0] app_wdf_mask;
    logic                app_wdf_rdy;
    logic [LINE_W-1:0]   app_rd_data;
    logic                app_rd_data_valid;
    logic                bridge_error;

    int totalChecks;
    int badChecks;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] rdata;
        logic [ADDR_W-1:0] expAddr;
    } readVecT;

    readVecT vecs[3];

    ddr2_line_bridge #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .ddr2_enable(ddr2_enable),
        .ddr2_read(ddr2_read),
        .ddr2_addr(ddr2_addr),
        .ddr2_wdata(ddr2_wdata),
        .ddr2_available(ddr2_available),
        .ddr2_data(ddr2_data),
        .app_addr(app_addr),
        .app_cmd(app_cmd),
        .app_en(app_en),
        .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data),
        .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask),
        .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid),
        .bridge_error(bridge_error)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs and checks happen 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One line read with a MIG that accepts at once and returns data one
    // cycle after the command.
    task automatic applyStimulus(input readVecT v);
        ddr2_enable = 1'b1;
        ddr2_read   = 1'b1;
        ddr2_addr   = v.addr;
        app_rdy     = 1'b1;
        tick();
        checkOutput("rd_capture_en", app_en, 0);
        tick();
        checkOutput("rd_issue_en", app_en, 1);
        checkOutput("rd_issue_cmd", app_cmd, 3'b001);
        checkOutput("rd_issue_addr", app_addr, v.expAddr);
        checkOutput("rd_issue_wren", app_wdf_wren, 0);
        tick();
        checkOutput("rd_wait_en", app_en, 0);
        app_rd_data       = v.rdata;
        app_rd_data_valid = 1'b1;
        tick();
        checkOutput("rd_ack_avail", ddr2_available, 1);
        checkOutput("rd_ack_data", ddr2_data, v.rdata);
        checkOutput("rd_ack_err", bridge_error, 0);
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
        ddr2_enable       = 1'b0;
        tick();
        checkOutput("rd_post_avail", ddr2_available, 0);
        checkOutput("rd_post_hold", ddr2_data, v.rdata);
        checkOutput("rd_post_en", app_en, 0);
        tick();
        checkOutput("rd_no_reissue", app_en, 0);
        checkOutput("rd_single_pulse", ddr2_available, 0);
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;

        vecs[0] = '{addr: 27'h0001234, rdata: 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5,
                    expAddr: 27'h0001230};
        vecs[1] = '{addr: 27'h7FFFFFF, rdata: 128'h0123456789ABCDEFFEDCBA9876543210,
                    expAddr: 27'h7FFFFF0};
        vecs[2] = '{addr: 27'h000000F, rdata: 128'hFFFFFFFF00000000FFFFFFFF00000001,
                    expAddr: 27'h0000000};

        rstn              = 1'b1;
        ddr2_enable       = 1'b0;
        ddr2_read         = 1'b0;
        ddr2_addr         = '0;
        ddr2_wdata        = '0;
        app_rdy           = 1'b1;
        app_wdf_rdy       = 1'b1;
        app_rd_data       = '0;
        app_rd_data_valid = 1'b0;

        // Reset values.
        #2 rstn = 1'b0;
        #1;
        checkOutput("rst_avail", ddr2_available, 0);
        checkOutput("rst_data", ddr2_data, 0);
        checkOutput("rst_addr", app_addr, 0);
        checkOutput("rst_en", app_en, 0);
        checkOutput("rst_wren", app_wdf_wren, 0);
        checkOutput("rst_err", bridge_error, 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Table-driven reads.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i]);
        end

        // Writeback then fill: write must reach the MIG before the read.
        ddr2_enable = 1'b1;
        ddr2_read   = 1'b0;
        ddr2_addr   = 27'h0004000;
        ddr2_wdata  = 128'h11111111111111111111111111111111;
        tick();
        checkOutput("wf_capture_en", app_en, 0);
        ddr2_read = 1'b1;
        ddr2_addr = 27'h0008000;
        tick();
        checkOutput("wf_wr_en", app_en, 1);
        checkOutput("wf_wr_cmd", app_cmd, 3'b000);
        checkOutput("wf_wr_addr", app_addr, 27'h0004000);
        checkOutput("wf_wr_wren", app_wdf_wren, 1);
        checkOutput("wf_wr_end", app_wdf_end, 1);
        checkOutput("wf_wr_data", app_wdf_data, 128'h11111111111111111111111111111111);
        checkOutput("wf_wr_mask", app_wdf_mask, 0);
        tick();
        checkOutput("wf_idle_en", app_en, 0);
        checkOutput("wf_idle_wren", app_wdf_wren, 0);
        tick();
        checkOutput("wf_rd_en", app_en, 1);
        checkOutput("wf_rd_cmd", app_cmd, 3'b001);
        checkOutput("wf_rd_addr", app_addr, 27'h0008000);
        tick();
        app_rd_data       = 128'h22222222222222222222222222222222;
        app_rd_data_valid = 1'b1;
        tick();
        checkOutput("wf_ack_avail", ddr2_available, 1);
        checkOutput("wf_ack_data", ddr2_data, 128'h22222222222222222222222222222222);
        app_rd_data_valid = 1'b0;
        ddr2_enable       = 1'b0;
        tick();
        checkOutput("wf_post_avail", ddr2_available, 0);
        checkOutput("wf_post_en", app_en, 0);

        // Command backpressure: data accepted at once, command held 5 cycles.
        ddr2_enable = 1'b1;
        ddr2_read   = 1'b0;
        ddr2_addr   = 27'h0010019;
        ddr2_wdata  = 128'h33333333333333333333333333333333;
        app_rdy     = 1'b0;
        tick();
        ddr2_enable = 1'b0;
        tick();
        checkOutput("bp_c1_en", app_en, 1);
        checkOutput("bp_c1_wren", app_wdf_wren, 1);
        checkOutput("bp_c1_addr", app_addr, 27'h0010010);
        for (int k = 2; k <= 5; k++) begin
            tick();
            checkOutput("bp_hold_en", app_en, 1);
            checkOutput("bp_hold_wren", app_wdf_wren, 0);
        end
        tick();
        checkOutput("bp_c6_en", app_en, 1);
        app_rdy = 1'b1;
        tick();
        checkOutput("bp_done_en", app_en, 0);
        checkOutput("bp_done_wren", app_wdf_wren, 0);
        tick();
        checkOutput("bp_cleared_en", app_en, 0);

        // Write-data backpressure: command accepted at once.
        ddr2_enable = 1'b1;
        ddr2_addr   = 27'h0000020;
        ddr2_wdata  = 128'h44444444444444444444444444444444;
        app_wdf_rdy = 1'b0;
        tick();
        ddr2_enable = 1'b0;
        tick();
        checkOutput("dbp_c1_en", app_en, 1);
        checkOutput("dbp_c1_wren", app_wdf_wren, 1);
        tick();
        checkOutput("dbp_c2_en", app_en, 0);
        checkOutput("dbp_c2_wren", app_wdf_wren, 1);
        app_wdf_rdy = 1'b1;
        tick();
        checkOutput("dbp_done_wren", app_wdf_wren, 0);
        checkOutput("dbp_done_en", app_en, 0);

        // A second write while the buffer is full is dropped.
        ddr2_enable = 1'b1;
        ddr2_addr   = 27'h0000030;
        ddr2_wdata  = 128'h55555555555555555555555555555555;
        tick();
        ddr2_addr  = 27'h0000040;
        ddr2_wdata = 128'h66666666666666666666666666666666;
        tick();
        ddr2_enable = 1'b0;
        checkOutput("drop_addr", app_addr, 27'h0000030);
        checkOutput("drop_data", app_wdf_data, 128'h55555555555555555555555555555555);
        tick();
        checkOutput("drop_idle_en", app_en, 0);
        tick();
        checkOutput("drop_no_second", app_en, 0);

`ifdef DDR2_TIMEOUT_EN
        // Read watchdog: MIG never accepts the command.
        ddr2_enable = 1'b1;
        ddr2_read   = 1'b1;
        ddr2_addr   = 27'h0000060;
        app_rdy     = 1'b0;
        tick();
        tick();
        checkOutput("to_issue_en", app_en, 1);
        for (int k = 0; k < 15; k++) begin
            tick();
            checkOutput("to_wait_avail", ddr2_available, 0);
        end
        tick();
        checkOutput("to_ack_avail", ddr2_available, 1);
        checkOutput("to_ack_data", ddr2_data, 0);
        checkOutput("to_ack_err", bridge_error, 1);
        ddr2_enable = 1'b0;
        app_rdy     = 1'b1;
        tick();
        checkOutput("to_sticky_err", bridge_error, 1);
        checkOutput("to_post_avail", ddr2_available, 0);
        tick();
`endif

        // Reset in the middle of RD_WAIT, then a late stray read response.
        ddr2_enable = 1'b1;
        ddr2_read   = 1'b1;
        ddr2_addr   = 27'h0000050;
        app_rdy     = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("mid_wait_en", app_en, 0);
        ddr2_enable = 1'b0;
        rstn        = 1'b0;
        #1;
        checkOutput("mid_rst_avail", ddr2_available, 0);
        checkOutput("mid_rst_data", ddr2_data, 0);
        checkOutput("mid_rst_addr", app_addr, 0);
        checkOutput("mid_rst_en", app_en, 0);
        checkOutput("mid_rst_err", bridge_error, 0);
        tick();
        rstn              = 1'b1;
        app_rd_data       = 128'h77777777777777777777777777777777;
        app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
        checkOutput("stray_avail", ddr2_available, 0);
        checkOutput("stray_data", ddr2_data, 0);
        tick();
        checkOutput("stray_avail2", ddr2_available, 0);
        checkOutput("stray_en", app_en, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
